// File: rtl/lic_irq_ctrl.sv
// ---------------------------------------------------------------------------
// lic_irq_ctrl
//
// Purpose
//   Interrupt request controller sitting between the local interrupt
//   controller (lic) and the core exception unit (excp). It samples the timer,
//   software and external interrupt levels into the mip pending register. It
//   gates the pending bits with mie / mstatus.MIE and picks one source by fixed
//   priority (external > software > timer). It then raises a registered request
//   with a stable mcause code until excp accepts it, and tracks handler
//   occupancy until mret.
//
// Parameters
//   EXT_SYNC_STAGES  flop stages on the asynchronous ext_irq input (2..3)
//   CNT_W            width of the saturating taken-interrupt counter
//
// Ports
//   clk              in   core clock
//   reset            in   asynchronous, active-high reset
//   lic_timer_irq    in   timer level (mtime >= mtimecmp) from lic
//   lic_soft_irq     in   software level (msip) from lic
//   ext_irq          in   asynchronous external level, unsynchronised
//   csr_mstatus_mie  in   global machine interrupt enable
//   csr_mie          in   {meie, mtie, msie}
//   excp_irq_ack     in   excp takes the request this cycle
//   excp_mret        in   mret retired this cycle
//   irq_req          out  registered request to excp
//   irq_cause        out  mcause code: 11 ext, 3 soft, 7 timer
//   irq_mip          out  {meip, mtip, msip} pending bits to csr
//   irq_active       out  handler in progress
//   irq_count        out  saturating count of acknowledged interrupts
// ---------------------------------------------------------------------------
module lic_irq_ctrl #(
    parameter int EXT_SYNC_STAGES = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lic_timer_irq,
    input  logic             lic_soft_irq,
    input  logic             ext_irq,
    input  logic             csr_mstatus_mie,
    input  logic [2:0]       csr_mie,
    input  logic             excp_irq_ack,
    input  logic             excp_mret,
    output logic             irq_req,
    output logic [3:0]       irq_cause,
    output logic [2:0]       irq_mip,
    output logic             irq_active,
    output logic [CNT_W-1:0] irq_count
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_HANDLER = 2'd2;

    // mcause exception codes
    localparam logic [3:0] CAUSE_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_SOFT  = 4'd3;
    localparam logic [3:0] CAUSE_TIMER = 4'd7;

    // mip / mie bit positions
    localparam int BIT_SOFT  = 0;
    localparam int BIT_TIMER = 1;
    localparam int BIT_EXT   = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // External interrupt synchroniser. Bit 0 samples the raw pin; the MSB
    // is the metastability-safe level that feeds the mip register.
    // ------------------------------------------------------------------
    logic [EXT_SYNC_STAGES-1:0] ext_sync_q;
    logic                       ext_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_sync_q <= '0;
        end else begin
            ext_sync_q <= {ext_sync_q[EXT_SYNC_STAGES-2:0], ext_irq};
        end
    end

    assign ext_sync = ext_sync_q[EXT_SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Pending register. Samples every cycle regardless of enables or FSM
    // state so csr always sees the raw pending picture.
    // ------------------------------------------------------------------
    logic [2:0] mip_q;
    logic [2:0] mip_d;

    always_comb begin
        mip_d            = '0;
        mip_d[BIT_EXT]   = ext_sync;
        mip_d[BIT_TIMER] = lic_timer_irq;
        mip_d[BIT_SOFT]  = lic_soft_irq;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mip_q <= '0;
        end else begin
            mip_q <= mip_d;
        end
    end

    // ------------------------------------------------------------------
    // Enable gating and priority selection (from the registered mip).
    // ------------------------------------------------------------------
    logic [2:0] pend;
    logic       take;
    logic [3:0] sel_cause;

    always_comb begin
        pend = mip_q & csr_mie;
        take = (|pend) & csr_mstatus_mie;
    end

    // Fixed priority: external, then software, then timer. When nothing
    // is pending the value is never used because take is low.
    always_comb begin
        sel_cause = CAUSE_TIMER;
        if (pend[BIT_EXT]) begin
            sel_cause = CAUSE_EXT;
        end else if (pend[BIT_SOFT]) begin
            sel_cause = CAUSE_SOFT;
        end else if (pend[BIT_TIMER]) begin
            sel_cause = CAUSE_TIMER;
        end
    end

    // ------------------------------------------------------------------
    // Request / handler FSM
    // ------------------------------------------------------------------
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [3:0]       cause_q;
    logic [3:0]       cause_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             req_q;
    logic             req_d;
    logic             active_q;
    logic             active_d;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                // Stray acks are ignored here; the cause is latched only
                // when a request is actually launched.
                if (take) begin
                    state_d = ST_REQ;
                    cause_d = sel_cause;
                end
            end

            ST_REQ: begin
                // The cause stays frozen while requesting so excp never
                // sees it change under an outstanding request. An ack takes
                // precedence over a simultaneous loss of take.
                if (excp_irq_ack) begin
                    state_d = ST_HANDLER;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (!take) begin
                    state_d = ST_IDLE;
                end
            end

            ST_HANDLER: begin
                // New pends only show up in mip; re-arbitration happens
                // from IDLE after mret, one cycle later.
                if (excp_mret) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are plain flops.
    always_comb begin
        req_d    = (state_d == ST_REQ);
        active_d = (state_d == ST_HANDLER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
            req_q    <= req_d;
            active_q <= active_d;
        end
    end

    assign irq_req    = req_q;
    assign irq_cause  = cause_q;
    assign irq_mip    = mip_q;
    assign irq_active = active_q;
    assign irq_count  = count_q;

endmodule

// File: tb/tb_lic_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lic_irq_ctrl
//
// Directed testbench for lic_irq_ctrl. The driver applies inputs on the
// falling edge and queues the hand-computed output tuple expected after the
// next rising edge. A separate monitor pops one entry per rising edge and
// compares it with the DUT outputs sampled 1 time unit after that edge.
// CNT_W is set to 2 so that counter saturation is reachable.
// ---------------------------------------------------------------------------
module tb_lic_irq_ctrl;

    localparam int CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             lic_timer_irq;
    logic             lic_soft_irq;
    logic             ext_irq;
    logic             csr_mstatus_mie;
    logic [2:0]       csr_mie;
    logic             excp_irq_ack;
    logic             excp_mret;
    logic             irq_req;
    logic [3:0]       irq_cause;
    logic [2:0]       irq_mip;
    logic             irq_active;
    logic [CNT_W-1:0] irq_count;

    lic_irq_ctrl #(
        .EXT_SYNC_STAGES(2),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lic_timer_irq  (lic_timer_irq),
        .lic_soft_irq   (lic_soft_irq),
        .ext_irq        (ext_irq),
        .csr_mstatus_mie(csr_mstatus_mie),
        .csr_mie        (csr_mie),
        .excp_irq_ack   (excp_irq_ack),
        .excp_mret      (excp_mret),
        .irq_req        (irq_req),
        .irq_cause      (irq_cause),
        .irq_mip        (irq_mip),
        .irq_active     (irq_active),
        .irq_count      (irq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             req;
        logic [3:0]       cause;
        logic [2:0]       mip;
        logic             act;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input exp_t e);
        n_cmp++;
        if (irq_req !== e.req || irq_cause !== e.cause || irq_mip !== e.mip ||
            irq_active !== e.act || irq_count !== e.cnt) begin
            n_bad++;
            $display("FAIL %s: got req=%0b cause=%0d mip=%b act=%0b cnt=%0d, want req=%0b cause=%0d mip=%b act=%0b cnt=%0d",
                     e.name, irq_req, irq_cause, irq_mip, irq_active, irq_count,
                     e.req, e.cause, e.mip, e.act, e.cnt);
        end else begin
            $display("ok   %s: req=%0b cause=%0d mip=%b act=%0b cnt=%0d",
                     e.name, irq_req, irq_cause, irq_mip, irq_active, irq_count);
        end
    endtask

    // Monitor: one expectation per rising edge, if one is queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e);
            end
        end
    end

    // Queue the outputs expected after the next rising edge, then move on
    // to the following falling edge where the next inputs are applied.
    task automatic tick(input string nm, input logic r, input logic [3:0] c,
                        input logic [2:0] m, input logic a, input logic [CNT_W-1:0] n);
        exp_t e;
        e.name  = nm;
        e.req   = r;
        e.cause = c;
        e.mip   = m;
        e.act   = a;
        e.cnt   = n;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [CNT_W-1:0] c_prev;
        logic [CNT_W-1:0] c_now;
        logic [3:0]       cz;

        reset           = 1'b1;
        lic_timer_irq   = 1'b0;
        lic_soft_irq    = 1'b0;
        ext_irq         = 1'b0;
        csr_mstatus_mie = 1'b0;
        csr_mie         = 3'b000;
        excp_irq_ack    = 1'b0;
        excp_mret       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick("rst_release", 0, 0, 3'b000, 0, 0);

        // Timer request, ack, handler, mret with timer still high
        csr_mstatus_mie = 1'b1;
        csr_mie         = 3'b010;
        lic_timer_irq   = 1'b1;
        tick("t2_mip",   0, 0, 3'b010, 0, 0);
        tick("t2_req",   1, 7, 3'b010, 0, 0);
        tick("t2_hold",  1, 7, 3'b010, 0, 0);
        excp_irq_ack = 1'b1;
        tick("t2_ack",   0, 7, 3'b010, 1, 1);
        excp_irq_ack = 1'b0;
        tick("t2_hdl",   0, 7, 3'b010, 1, 1);
        excp_mret = 1'b1;
        tick("t2_mret",  0, 7, 3'b010, 0, 1);
        excp_mret = 1'b0;
        tick("t2_rereq", 1, 7, 3'b010, 0, 1);
        excp_irq_ack = 1'b1;
        tick("t2_ack2",  0, 7, 3'b010, 1, 2);
        excp_irq_ack  = 1'b0;
        lic_timer_irq = 1'b0;
        tick("t2_tdrop", 0, 7, 3'b000, 1, 2);
        excp_mret = 1'b1;
        tick("t2_mret2", 0, 7, 3'b000, 0, 2);
        excp_mret = 1'b0;

        // Stray ack in IDLE, stray mret in REQ
        excp_irq_ack = 1'b1;
        tick("t5_ack_idle", 0, 7, 3'b000, 0, 2);
        excp_irq_ack  = 1'b0;
        lic_timer_irq = 1'b1;
        tick("t5_mip",      0, 7, 3'b010, 0, 2);
        tick("t5_req",      1, 7, 3'b010, 0, 2);
        excp_mret = 1'b1;
        tick("t5_mret_req", 1, 7, 3'b010, 0, 2);
        excp_mret = 1'b0;

        // Withdraw on MIE clear, then ack wins over simultaneous MIE clear
        csr_mstatus_mie = 1'b0;
        tick("t4_withdraw", 0, 7, 3'b010, 0, 2);
        tick("t4_idle",     0, 7, 3'b010, 0, 2);
        csr_mstatus_mie = 1'b1;
        tick("t4_rereq",    1, 7, 3'b010, 0, 2);
        csr_mstatus_mie = 1'b0;
        excp_irq_ack    = 1'b1;
        tick("t4_ack_win",  0, 7, 3'b010, 1, 3);
        excp_irq_ack    = 1'b0;
        csr_mstatus_mie = 1'b1;
        tick("t4_hdl",      0, 7, 3'b010, 1, 3);

        // One more round with the counter already at its maximum
        excp_mret = 1'b1;
        tick("sat_mret", 0, 7, 3'b010, 0, 3);
        excp_mret = 1'b0;
        tick("sat_req",  1, 7, 3'b010, 0, 3);
        excp_irq_ack = 1'b1;
        tick("sat_ack",  0, 7, 3'b010, 1, 3);
        excp_irq_ack = 1'b0;

        // Priority: timer and ext rise together, ext is 3 cycles late
        lic_timer_irq = 1'b0;
        excp_mret     = 1'b1;
        tick("t3_idle", 0, 7, 3'b000, 0, 3);
        excp_mret     = 1'b0;
        csr_mie       = 3'b111;
        lic_timer_irq = 1'b1;
        ext_irq       = 1'b1;
        tick("t3_a",      0, 7, 3'b010, 0, 3);
        tick("t3_b",      1, 7, 3'b010, 0, 3);
        tick("t3_frozen", 1, 7, 3'b110, 0, 3);
        excp_irq_ack = 1'b1;
        tick("t3_ack",    0, 7, 3'b110, 1, 3);
        excp_irq_ack  = 1'b0;
        lic_timer_irq = 1'b0;
        excp_mret     = 1'b1;
        tick("t3_mret",   0, 7, 3'b100, 0, 3);
        excp_mret = 1'b0;
        tick("t3_ext_req", 1, 11, 3'b100, 0, 3);
        excp_irq_ack = 1'b1;
        tick("t3_ack2",    0, 11, 3'b100, 1, 3);
        excp_irq_ack = 1'b0;
        ext_irq      = 1'b0;
        tick("t3_e1", 0, 11, 3'b100, 1, 3);
        tick("t3_e2", 0, 11, 3'b100, 1, 3);
        tick("t3_e3", 0, 11, 3'b000, 1, 3);

        // Software beats timer; a later ext arrival does not disturb REQ
        lic_soft_irq  = 1'b1;
        lic_timer_irq = 1'b1;
        tick("t3_st",    0, 11, 3'b011, 1, 3);
        excp_mret = 1'b1;
        tick("t3_mret2", 0, 11, 3'b011, 0, 3);
        excp_mret = 1'b0;
        tick("t3_soft_req", 1, 3, 3'b011, 0, 3);
        ext_irq = 1'b1;
        tick("t3_x1", 1, 3, 3'b011, 0, 3);
        tick("t3_x2", 1, 3, 3'b011, 0, 3);
        tick("t3_x3", 1, 3, 3'b111, 0, 3);
        excp_irq_ack = 1'b1;
        tick("t3_ack3",  0, 3, 3'b111, 1, 3);
        excp_irq_ack = 1'b0;
        excp_mret    = 1'b1;
        tick("t3_mret3", 0, 3, 3'b111, 0, 3);
        excp_mret = 1'b0;
        tick("t3_ext_win", 1, 11, 3'b111, 0, 3);

        // Asynchronous reset while requesting
        reset         = 1'b1;
        lic_soft_irq  = 1'b0;
        lic_timer_irq = 1'b0;
        ext_irq       = 1'b0;
        #1;
        e.name  = "t1_async";
        e.req   = 1'b0;
        e.cause = 4'd0;
        e.mip   = 3'b000;
        e.act   = 1'b0;
        e.cnt   = '0;
        cmp(e);
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        csr_mie = 3'b010;
        tick("t1_release", 0, 0, 3'b000, 0, 0);

        // Five timer rounds: count 1, 2, 3, 3, 3
        for (int k = 1; k <= 5; k++) begin
            c_prev = (k - 1 > 3) ? CNT_W'(3) : CNT_W'(k - 1);
            c_now  = (k > 3) ? CNT_W'(3) : CNT_W'(k);
            cz     = (k == 1) ? 4'd0 : 4'd7;
            lic_timer_irq = 1'b1;
            tick($sformatf("t6_r%0d_mip", k), 0, cz, 3'b010, 0, c_prev);
            tick($sformatf("t6_r%0d_req", k), 1, 7,  3'b010, 0, c_prev);
            excp_irq_ack = 1'b1;
            tick($sformatf("t6_r%0d_ack", k), 0, 7,  3'b010, 1, c_now);
            excp_irq_ack  = 1'b0;
            lic_timer_irq = 1'b0;
            excp_mret     = 1'b1;
            tick($sformatf("t6_r%0d_mret", k), 0, 7, 3'b000, 0, c_now);
            excp_mret = 1'b0;
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d queued, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
